// File: rtl/fifo_uart_pkg.sv
// Shared definitions for the FIFO-draining UART transmitter.
package fifo_uart_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    POP   = 3'd1,
    LOAD  = 3'd2,
    START = 3'd3,
    DATA  = 3'd4,
    STOP  = 3'd5
  } uart_state_t;

  // Start and stop bits wrapped around every data word.
  localparam int unsigned FRAME_OVERHEAD_BITS = 2;

  // Serial bit periods in one frame for a given data width.
  function automatic int unsigned frame_bits(input int unsigned width);
    return width + FRAME_OVERHEAD_BITS;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Baud divider: free-running 0..CLKS_PER_BIT-1 counter, restarted by clear.
module uart_bit_timer
  import fifo_uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic bit_tick
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  assign bit_tick = (cnt == LAST_CNT);

  // Count clock cycles within the current bit period.
  always_ff @(posedge clk) begin
    if (rst || clear || bit_tick) cnt <= '0;
    else                          cnt <= cnt + CW'(1);
  end

endmodule

// File: rtl/fifo_uart_tx.sv
// Pops words from a synchronous FIFO and sends each as an 8N1-style frame.
module fifo_uart_tx
  import fifo_uart_pkg::*;
#(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_rd_data,
  output logic             fifo_rd_en,
  output logic             tx,
  output logic             busy,
  output logic             frame_done,
  output logic [15:0]      frame_cnt
);

  localparam int unsigned BW = $clog2(WIDTH) + 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  uart_state_t      state, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic             tx_d;
  logic             bit_tick;

  uart_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (state_d != state),
    .bit_tick(bit_tick)
  );

  assign fifo_rd_en = (state == POP);
  assign busy       = (state != IDLE);

  // Next-state, shift/bit bookkeeping and the value tx takes next cycle.
  always_comb begin
    state_d    = state;
    shift_d    = shift_q;
    bit_d      = bit_q;
    frame_done = 1'b0;
    case (state)
      IDLE:  if (enable && !fifo_empty) state_d = POP;
      POP:   state_d = LOAD;
      LOAD: begin
        state_d = START;
        shift_d = fifo_rd_data;
        bit_d   = '0;
      end
      START: if (bit_tick) state_d = DATA;
      DATA: begin
        if (bit_tick) begin
          shift_d = shift_q >> 1;
          if (bit_q == LAST_BIT) state_d = STOP;
          else                   bit_d   = bit_q + BW'(1);
        end
      end
      STOP: begin
        if (bit_tick) begin
          frame_done = 1'b1;
          state_d    = (enable && !fifo_empty) ? POP : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // tx is registered from the upcoming state so it lines up with the state register.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  // State register, datapath registers and frame counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      shift_q   <= '0;
      bit_q     <= '0;
      tx        <= 1'b1;
      frame_cnt <= '0;
    end else begin
      state   <= state_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      tx      <= tx_d;
      if (frame_done) frame_cnt <= frame_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx with a behavioural FIFO read port.
module tb_fifo_uart_tx;
  import fifo_uart_pkg::*;

  localparam int unsigned W   = 8;
  localparam int unsigned CPB = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         enable = 1'b0;
  logic         fifo_empty;
  logic [W-1:0] fifo_rd_data = '0;
  logic         fifo_rd_en;
  logic         tx;
  logic         busy;
  logic         frame_done;
  logic [15:0]  frame_cnt;

  int n_total = 0;
  int n_bad   = 0;
  int n_rd    = 0;
  int n_done  = 0;

  // Behavioural FIFO: data appears the cycle after a sampled pop.
  logic [W-1:0] fmem [16];
  int unsigned  wr_ptr = 0;
  int unsigned  rd_ptr = 0;
  logic         rd_error = 1'b0;

  assign fifo_empty = (wr_ptr == rd_ptr);

  always #5 clk = ~clk;

  fifo_uart_tx #(
    .WIDTH       (W),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .fifo_empty  (fifo_empty),
    .fifo_rd_data(fifo_rd_data),
    .fifo_rd_en  (fifo_rd_en),
    .tx          (tx),
    .busy        (busy),
    .frame_done  (frame_done),
    .frame_cnt   (frame_cnt)
  );

  always @(posedge clk) begin
    if (fifo_rd_en) begin
      if (fifo_empty) rd_error <= 1'b1;
      else begin
        fifo_rd_data <= fmem[rd_ptr % 16];
        rd_ptr       <= rd_ptr + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (fifo_rd_en) n_rd++;
    if (frame_done) n_done++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input logic [W-1:0] d);
    fmem[wr_ptr % 16] = d;
    wr_ptr++;
  endtask

  // Entered at the first START cycle; returns at the cycle after the stop bit.
  task automatic check_frame(input logic [W-1:0] d, input string tag);
    logic [9:0] bits;
    logic [3:0] samp;
    logic       last_done;
    int         done0;
    int         busy_low;
    bits      = {1'b1, d, 1'b0};
    done0     = n_done;
    busy_low  = 0;
    last_done = 1'b0;
    for (int b = 0; b < 10; b++) begin
      for (int c = 0; c < 4; c++) begin
        samp[c] = tx;
        if (!busy) busy_low++;
        if (b == 9 && c == 3) last_done = frame_done;
        tick();
      end
      check_eq($sformatf("%s_bit%0d", tag, b), 32'(samp), 32'({4{bits[b]}}));
    end
    check_eq({tag, "_done_last"}, 32'(last_done), 32'd1);
    check_eq({tag, "_done_once"}, 32'(n_done - done0), 32'd1);
    check_eq({tag, "_busy"}, 32'(busy_low), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rd0, done0, act;

    // Reset state
    tick(2);
    check_eq("rst_tx", 32'(tx), 32'd1);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_rden", 32'(fifo_rd_en), 32'd0);
    check_eq("rst_done", 32'(frame_done), 32'd0);
    check_eq("rst_cnt", 32'(frame_cnt), 32'd0);
    rst = 1'b0;
    tick();
    check_eq("frame_len", 32'(frame_bits(W) * CPB), 32'd40);

    // 1: single 0xA5 frame
    rd0 = n_rd;
    push(8'hA5);
    enable = 1'b1;
    tick();
    check_eq("t1_rden", 32'(fifo_rd_en), 32'd1);
    tick();
    check_eq("t1_load_tx", 32'(tx), 32'd1);
    check_eq("t1_load_rden", 32'(fifo_rd_en), 32'd0);
    tick();
    check_frame(8'hA5, "t1");
    check_eq("t1_idle", 32'(busy), 32'd0);
    check_eq("t1_cnt", 32'(frame_cnt), 32'd1);
    check_eq("t1_empty", 32'(fifo_empty), 32'd1);
    check_eq("t1_rd_pulses", 32'(n_rd - rd0), 32'd1);

    // 2: back-to-back 0x00, 0xFF
    rd0 = n_rd;
    push(8'h00);
    push(8'hFF);
    tick(3);
    check_frame(8'h00, "t2a");
    check_eq("t2_gap1_tx", 32'(tx), 32'd1);
    check_eq("t2_gap1_busy", 32'(busy), 32'd1);
    tick();
    check_eq("t2_gap2_tx", 32'(tx), 32'd1);
    check_eq("t2_gap2_busy", 32'(busy), 32'd1);
    tick();
    check_frame(8'hFF, "t2b");
    check_eq("t2_rd_pulses", 32'(n_rd - rd0), 32'd2);
    check_eq("t2_cnt", 32'(frame_cnt), 32'd3);
    check_eq("t2_idle", 32'(busy), 32'd0);

    // 3: empty FIFO, enabled, 100 cycles
    rd0 = n_rd;
    act = 0;
    for (int i = 0; i < 100; i++) begin
      if (busy || !tx || fifo_rd_en) act++;
      tick();
    end
    check_eq("t3_activity", 32'(act), 32'd0);
    check_eq("t3_rd_pulses", 32'(n_rd - rd0), 32'd0);
    check_eq("t3_rd_error", 32'(rd_error), 32'd0);

    // 4: word waits while disabled, starts 3 cycles after enable
    enable = 1'b0;
    push(8'h3C);
    act = 0;
    for (int i = 0; i < 50; i++) begin
      if (busy || !tx || fifo_rd_en) act++;
      tick();
    end
    check_eq("t4_quiet", 32'(act), 32'd0);
    enable = 1'b1;
    tick();
    check_eq("t4_c1_tx", 32'(tx), 32'd1);
    tick();
    check_eq("t4_c2_tx", 32'(tx), 32'd1);
    tick();
    check_frame(8'h3C, "t4");
    check_eq("t4_cnt", 32'(frame_cnt), 32'd4);

    // 5: reset during third data bit of 0x81
    push(8'h81);
    tick(3);
    done0 = n_done;
    tick(13);
    check_eq("t5_bit2_tx", 32'(tx), 32'd0);
    check_eq("t5_busy_pre", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    check_eq("t5_tx", 32'(tx), 32'd1);
    check_eq("t5_busy", 32'(busy), 32'd0);
    check_eq("t5_cnt", 32'(frame_cnt), 32'd0);
    check_eq("t5_no_done", 32'(n_done - done0), 32'd0);
    rst = 1'b0;
    rd0 = n_rd;
    act = 0;
    for (int i = 0; i < 20; i++) begin
      if (busy || !tx) act++;
      tick();
    end
    check_eq("t5_stay_idle", 32'(act), 32'd0);
    check_eq("t5_rd_pulses", 32'(n_rd - rd0), 32'd0);

    // 6: enable dropped during START of 0x55, 0x66 stays queued
    rd0 = n_rd;
    push(8'h55);
    push(8'h66);
    tick(3);
    enable = 1'b0;
    check_frame(8'h55, "t6");
    check_eq("t6_idle", 32'(busy), 32'd0);
    tick(20);
    check_eq("t6_idle_late", 32'(busy), 32'd0);
    check_eq("t6_rd_pulses", 32'(n_rd - rd0), 32'd1);
    check_eq("t6_not_empty", 32'(fifo_empty), 32'd0);
    check_eq("t6_queued", 32'(fmem[rd_ptr % 16]), 32'h66);
    check_eq("t6_cnt", 32'(frame_cnt), 32'd1);
    check_eq("end_rd_error", 32'(rd_error), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
